dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data_memory between two requesters: port A (CPU MEM stage load/store)
//  and port B (debug/loader DMA). Port A is the priority port; a wait counter guarantees port B
//  service. Drives data_memory's mem_read/mem_write/address/write_data and returns registered read data.
// PARAMETERS
//  DEPTH        1024  words in data_memory; word addr >= DEPTH is out of range
//  STARVE_LIMIT 4     consecutive cycles B may wait before it is forced ahead of A (1..15)
// PORTS
//  clk          in   1   rising-edge clock (only clock)
//  rst          in   1   synchronous, active-high reset
//  a_req        in   1   A request; held until a_gnt
//  a_we         in   1   A: 1=store, 0=load
//  a_addr       in   32  A byte address (bits [1:0] ignored)
//  a_wdata      in   32  A store data
//  a_gnt        out  1   A request accepted this cycle (combinational)
//  a_rvalid     out  1   A response valid (1 cycle after a_gnt)
//  a_rdata      out  32  A load data, valid with a_rvalid
//  a_err        out  1   A response was out of range, valid with a_rvalid
//  b_req/b_we/b_addr/b_wdata/b_gnt/b_rvalid/b_rdata/b_err: same as A, port B
//  mem_read     out  1   to data_memory
//  mem_write    out  1   to data_memory
//  mem_addr     out  32  to data_memory address
//  mem_wdata    out  32  to data_memory write_data
//  mem_rdata    in   32  from data_memory read_data (combinational)
// BEHAVIOUR
//  - Reset: all gnt/rvalid/err/mem_read/mem_write = 0, rdata = 0, mem_addr/mem_wdata = 0,
//    wait_cnt = 0, FSM = IDLE. Reset mid-transaction drops any pending response (no rvalid).
//  - At most one grant per cycle. Grant rule, evaluated each cycle:
//    B forced if b_req && wait_cnt >= STARVE_LIMIT; else A if a_req; else B if b_req; else none.
//  - Granted cycle: mem_* driven combinationally from the winner; mem_read = ~we, mem_write = we.
//    If word addr (addr[31:2]) >= DEPTH: no mem_read/mem_write asserted, err flagged.
//  - Response: next cycle winner's rvalid = 1 for exactly one cycle; rdata = mem_rdata captured at the
//    grant-cycle posedge for loads, 0 for stores and errors; err = 1 iff out of range.
//    Stores also produce rvalid (write acknowledge). Loser's rvalid stays 0.
//  - Back-to-back: a new grant is allowed in the same cycle a previous response is valid
//    (throughput 1 access/cycle, latency 1).
//  - wait_cnt (4 bit): increments while b_req && !b_gnt, saturating at 15; clears on b_gnt or !b_req.
//  - FSM states (record of last grant, drives response muxing):
//    IDLE -> RESP_A on A grant, RESP_B on B grant; RESP_x -> RESP_A/RESP_B/IDLE per this cycle's grant.
//  - Requester dropping req before gnt: legal, no access, wait_cnt clears.
//  - a_addr/b_addr misaligned: low bits ignored, no error.
// STRUCTURE
//  - Shared package/header: FSM state encodings (IDLE, RESP_A, RESP_B), DEPTH default, STARVE_LIMIT default.
//  - One sub-module: dmem_arb_port_sel (pure grant logic: a_req, b_req, wait_cnt -> a_gnt, b_gnt).
//  - Counter, FSM, response registers live in the top.
// TESTING (bench instantiates dmem_arbiter + data_memory, array preloaded at 0x100 = {4,5,3,1,2})
//  1 A load 0x100 alone -> a_gnt same cycle, next cycle a_rvalid=1, a_rdata=4, a_err=0; b_* idle.
//  2 A and B both request one cycle (A load 0x104, B load 0x108) -> A granted first (rdata=5),
//    B granted next cycle, b_rvalid one cycle later, b_rdata=3.
//  3 A requests every cycle, B holds req -> B waits 4 cycles, granted on 5th; wait_cnt returns to 0.
//  4 B store 0x10C data 9, then A load 0x10C -> b_rvalid ack with rdata=0, then a_rdata=9.
//  5 A load 0x1000 (word 1024) -> no mem_read, a_rvalid=1, a_err=1, a_rdata=0; memory unchanged.
//  6 rst asserted in cycle after a_gnt -> a_rvalid stays 0, all outputs 0 next cycle, wait_cnt=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEPTH_DEF        = 1024;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int WAIT_W           = 4;

  // Record of which port (if any) was granted last cycle; selects the response path.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESP_A = 2'd1,
    ST_RESP_B = 2'd2
  } arb_state_e;

  // Word address beyond the memory array; byte offset bits are ignored.
  function automatic logic addr_oor(input logic [31:0] addr, input int depth);
    return {2'b00, addr[31:2]} >= 32'(depth);
  endfunction

endpackage

// File: rtl/dmem_arb_port_sel.sv
// Pure grant logic: A has priority unless B has waited STARVE_LIMIT cycles.
module dmem_arb_port_sel
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              a_req,
  input  logic              b_req,
  input  logic [WAIT_W-1:0] wait_cnt,
  output logic              a_gnt,
  output logic              b_gnt
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

  logic b_force;

  // Starved B jumps ahead of A; otherwise B only wins an otherwise idle cycle.
  always_comb begin
    b_force = b_req && (wait_cnt >= LIMIT);
    a_gnt   = a_req && !b_force;
    b_gnt   = b_req && (b_force || !a_req);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory; one access per
// cycle, response registered one cycle after the grant.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic              any_gnt;
  logic              win_we;
  logic [31:0]       win_addr;
  logic [31:0]       win_wdata;
  logic              oor;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  arb_state_e        state_q, state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Requests are masked during reset so no grant or memory strobe leaks out.
  dmem_arb_port_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_port_sel (
    .a_req    (a_req & ~rst),
    .b_req    (b_req & ~rst),
    .wait_cnt (wait_cnt_q),
    .a_gnt    (a_gnt),
    .b_gnt    (b_gnt)
  );

  // Route the winner to the memory; out-of-range accesses get no strobe.
  always_comb begin
    any_gnt   = a_gnt | b_gnt;
    win_we    = b_gnt ? b_we    : a_we;
    win_addr  = b_gnt ? b_addr  : a_addr;
    win_wdata = b_gnt ? b_wdata : a_wdata;
    oor       = any_gnt && addr_oor(win_addr, DEPTH);
    mem_read  = any_gnt && !win_we && !oor;
    mem_write = any_gnt &&  win_we && !oor;
    mem_addr  = any_gnt ? win_addr  : 32'd0;
    mem_wdata = any_gnt ? win_wdata : 32'd0;
  end

  // Next response record and B starvation counter.
  always_comb begin
    state_d = ST_IDLE;
    if (a_gnt)      state_d = ST_RESP_A;
    else if (b_gnt) state_d = ST_RESP_B;
    rdata_d = mem_read ? mem_rdata : 32'd0;
    err_d   = oor;
    if (!b_req || b_gnt)            wait_cnt_d = '0;
    else if (wait_cnt_q == '1)      wait_cnt_d = wait_cnt_q;
    else                            wait_cnt_d = wait_cnt_q + 1'b1;
  end

  // Response FSM and registers; reset discards any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Response is steered to whichever port was granted last cycle.
  always_comb begin
    a_rvalid = (state_q == ST_RESP_A);
    b_rvalid = (state_q == ST_RESP_B);
    a_rdata  = a_rvalid ? rdata_q : 32'd0;
    b_rdata  = b_rvalid ? rdata_q : 32'd0;
    a_err    = a_rvalid && err_q;
    b_err    = b_rvalid && err_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: arbiter plus a behavioural data memory preloaded at 0x100.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:1023];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: combinational read, synchronous write, image reloaded on reset.
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      mem[64] <= 32'd4; mem[65] <= 32'd5; mem[66] <= 32'd3;
      mem[67] <= 32'd1; mem[68] <= 32'd2;
    end else if (mem_write) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  task automatic next_cyc();
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    // Reset state
    chk("rst_a_gnt",    a_gnt, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_mem_rd",   mem_read, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wait",     dut.wait_cnt_q, 0);
    rst = 1'b0;
    next_cyc();

    // 1: lone A load
    drive_a(1, 0, 32'h100, 0); #1;
    chk("t1_a_gnt", a_gnt, 1);
    chk("t1_mem_rd", mem_read, 1);
    chk("t1_b_gnt", b_gnt, 0);
    next_cyc(); drive_a(0, 0, 0, 0);
    chk("t1_a_rvalid", a_rvalid, 1);
    chk("t1_a_rdata",  a_rdata, 4);
    chk("t1_a_err",    a_err, 0);
    chk("t1_b_rvalid", b_rvalid, 0);
    next_cyc();
    chk("t1_a_rvalid_pulse", a_rvalid, 0);

    // 2: simultaneous requests, A wins first
    drive_a(1, 0, 32'h104, 0); drive_b(1, 0, 32'h108, 0); #1;
    chk("t2_a_gnt", a_gnt, 1);
    chk("t2_b_gnt", b_gnt, 0);
    next_cyc(); drive_a(0, 0, 0, 0); #1;
    chk("t2_a_rvalid", a_rvalid, 1);
    chk("t2_a_rdata",  a_rdata, 5);
    chk("t2_b_gnt2",   b_gnt, 1);
    next_cyc(); drive_b(0, 0, 0, 0);
    chk("t2_b_rvalid", b_rvalid, 1);
    chk("t2_b_rdata",  b_rdata, 3);
    chk("t2_a_rvalid_lose", a_rvalid, 0);
    next_cyc();

    // 3: A every cycle, B starves for 4 cycles then is forced
    drive_a(1, 0, 32'h110, 0); drive_b(1, 0, 32'h100, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t3_wait%0d", i), dut.wait_cnt_q, i);
      chk($sformatf("t3_b_gnt%0d", i), b_gnt, 0);
      next_cyc();
    end
    #1;
    chk("t3_a_rdata",  a_rdata, 2);
    chk("t3_force_b",  b_gnt, 1);
    chk("t3_force_na", a_gnt, 0);
    next_cyc(); drive_b(0, 0, 0, 0);
    chk("t3_b_rvalid", b_rvalid, 1);
    chk("t3_b_rdata",  b_rdata, 4);
    chk("t3_a_rv0",    a_rvalid, 0);
    chk("t3_wait_clr", dut.wait_cnt_q, 0);
    drive_a(0, 0, 0, 0);
    next_cyc();

    // 4: B store then A load of the same word
    drive_b(1, 1, 32'h10C, 32'd9); #1;
    chk("t4_b_gnt", b_gnt, 1);
    chk("t4_mem_wr", mem_write, 1);
    next_cyc(); drive_b(0, 0, 0, 0); drive_a(1, 0, 32'h10C, 0); #1;
    chk("t4_b_rvalid", b_rvalid, 1);
    chk("t4_b_rdata",  b_rdata, 0);
    chk("t4_b_err",    b_err, 0);
    next_cyc(); drive_a(0, 0, 0, 0);
    chk("t4_a_rvalid", a_rvalid, 1);
    chk("t4_a_rdata",  a_rdata, 9);
    next_cyc();

    // 5: out-of-range load and store (word 1024 aliases word 0 in the model)
    drive_a(1, 0, 32'h1000, 0); #1;
    chk("t5_gnt", a_gnt, 1);
    chk("t5_no_rd", mem_read, 0);
    next_cyc(); drive_a(1, 1, 32'h1000, 32'hDEAD); #1;
    chk("t5_rvalid", a_rvalid, 1);
    chk("t5_err",    a_err, 1);
    chk("t5_rdata",  a_rdata, 0);
    chk("t5_no_wr",  mem_write, 0);
    next_cyc(); drive_a(0, 0, 0, 0);
    chk("t5_st_err", a_err, 1);
    chk("t5_mem0",   mem[0], 0);
    next_cyc();

    // 6: reset while a response is pending
    drive_a(1, 0, 32'h100, 0); drive_b(1, 0, 32'h104, 0);
    next_cyc(); #1;
    chk("t6_wait_pre", dut.wait_cnt_q, 1);
    chk("t6_a_gnt",    a_gnt, 1);
    rst = 1'b1;
    next_cyc();
    chk("t6_a_rvalid", a_rvalid, 0);
    chk("t6_b_rvalid", b_rvalid, 0);
    chk("t6_a_gnt_rst", a_gnt, 0);
    chk("t6_mem_rd",   mem_read, 0);
    chk("t6_wait",     dut.wait_cnt_q, 0);
    drive_a(0, 0, 0, 0); drive_b(0, 0, 0, 0);
    rst = 1'b0;
    next_cyc();

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
